cbus_mstr_if_wide: RTL
======================

Name: cbus_mstr_if_wide

Overview:
- Second-generation CBUS master front-end for the cbus2axi bridge.
- Converts CBUS master bursts into command-FIFO and write-data-FIFO pushes, and returns read data from the read FIFO.
- Generalised to DW = 32/64/128 with address-offset-aware beat count, command-FIFO backpressure, write burst length checking and read error propagation.
- Sits between the CBUS master port and the cbus2axi AXI-side engine.

Parameters:
- DW, 32, CBUS data width; legal values 32, 64, 128.
- AW, 32, address width.
- BCW, 10, byte-count width.
- BEATW, BCW-$clog2(DW/8)+1, beat-count field width (derived).

Ports:
- aclk  in  1  clock.
- areset_n  in  1  asynchronous active-low reset.
- cbus_m_req  in  1  request valid.
- cbus_m_cmd  in  1  0 = write, 1 = read.
- cbus_m_address  in  AW  byte address, valid on first beat.
- cbus_m_bytecnt  in  BCW  burst byte count, valid on first beat.
- cbus_m_amode  in  2  address mode, passed through.
- cbus_m_first  in  1  first beat.
- cbus_m_last  in  1  last beat.
- cbus_m_byten  in  DW/8  write byte enables.
- cbus_m_wdata  in  DW  write data.
- cbus_m_waccept  out  1  write beat accepted.
- cbus_m_rresp  out  1  read beat popped this cycle.
- cbus_m_rdatap  out  DW  read data, registered.
- cbus_m_rerr  out  1  read error for the beat in rdatap, registered.
- cwfifo_datain  out  AW+BEATW+3  command word {amode, cmd, beats, address}.
- cwfifo_wr_op  out  1  command push.
- cwfifo_afull  in  1  command FIFO almost full.
- dwfifo_datain  out  DW+DW/8+1  {last, byten, wdata}.
- dwfifo_wr_op  out  1  write-data push.
- dwfifo_afull  in  1  data FIFO almost full.
- rdfifo_dataout  in  DW+2  {err, last, rdata}.
- rdfifo_empty  in  1  read FIFO empty.
- rdfifo_rd_op  out  1  read FIFO pop.
- wr_len_err  out  1  one-cycle pulse on write burst length mismatch.

Behaviour:
- Reset: every output 0, FSM = IDLE, beat counter 0, expected beats 0. Reset mid-burst abandons the burst; no partial command is pushed afterwards.
- Beat count: OFFW = log2(DW/8); adj = bytecnt + address[OFFW-1:0], computed in BCW+1 bits; beats = ceil(adj / (DW/8)). bytecnt = 0 is a 0-beat command, pushed unchanged.
- FSM states:
  - IDLE → WBURST on an accepted write first beat with last = 0. A first & last write stays in IDLE.
  - IDLE → RWAIT on read command push.
  - WBURST → IDLE on accepted last beat.
  - RWAIT → IDLE on pop of an entry with last = 1.
- waccept (combinational) = req & ~cmd & ~dwfifo_afull & (state ≠ RWAIT) & (~first | ~cwfifo_afull).
- Write beats: each accepted beat gives dwfifo_wr_op = 1 next cycle with {last, byten, wdata}. An accepted first beat also gives cwfifo_wr_op = 1 next cycle with cmd = 0, the computed beats and the address. Latency 1 cycle; both outputs are single-cycle pulses.
- Write length check:
  - The beat counter resets on first and increments per accepted beat.
  - If last is accepted and count ≠ expected beats, wr_len_err pulses one cycle after last.
  - A first beat accepted while in WBURST (missing last) also pulses wr_len_err. A new command is pushed and the counter restarts.
- Read command: in IDLE, req & cmd & first & ~cwfifo_afull → cwfifo_wr_op next cycle with cmd = 1. While cwfifo_afull = 1 the read waits in IDLE with no push.
- Read data:
  - rdfifo_rd_op = rresp = req & cmd & (state == RWAIT) & ~rdfifo_empty (combinational).
  - rdatap and rerr load from the popped entry on the next clock edge and hold otherwise.
- rdfifo non-empty in IDLE/WBURST: no pop.
- Simultaneous afull deassertion and first beat: acceptance is evaluated on the current-cycle inputs only.

Decomposition:
- Package cbus2axi_pkg holds:
  - FSM state encoding (IDLE = 0, WBURST = 1, RWAIT = 2).
  - cwfifo/dwfifo/rdfifo field offset functions of DW/AW.
  - OFFW helper.
- One sub-module, cbus_beat_calc: a combinational beat-count calculator (bytecnt, addr offset → beats), parametrised by DW and BCW, reused by the AXI side.

Test Plan:
- DW = 64, write addr 0x1003, bytecnt 13, 3 beats → cwfifo beats = 2 (13+3 = 16 → 2). wr_len_err pulses one cycle after last, since 3 ≠ 2. dwfifo gets 3 pushes with last on the 3rd.
- DW = 32, single-beat write (first & last), addr 0x0, bytecnt 4 → one cwfifo push with beats = 1, one dwfifo push, FSM stays IDLE, no wr_len_err.
- cwfifo_afull = 1 during write first beat → waccept = 0, no pushes. Release afull → accepted next cycle; cwfifo and dwfifo push one cycle later.
- DW = 128, read addr 0x20, bytecnt 32 → cwfifo {cmd = 1, beats = 2}. rdfifo supplies 2 entries, the 2nd with last = 1 and err = 1 → rresp pulses twice; rdatap/rerr update one cycle after each pop; rerr = 1 on the final beat; FSM returns to IDLE.
- Write first beat during WBURST (last dropped) → wr_len_err pulse, new command pushed with its own address/beats.
- areset_n asserted mid-write-burst (beat 2 of 4) → all outputs 0 immediately. After release, a fresh first beat is accepted normally.

Source files
------------

// File: rtl/cbus2axi_pkg.sv
// Shared definitions for the cbus2axi bridge: master FSM encoding,
// FIFO word field positions and the address-offset width helper.
package cbus2axi_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_WBURST = 2'd1,
        ST_RWAIT  = 2'd2
    } mstr_st_e;

    function automatic int offw(input int dw);
        return $clog2(dw / 8);
    endfunction

    // command word {amode, cmd, beats, address}
    function automatic int cw_beats_lsb(input int aw);
        return aw;
    endfunction

    function automatic int cw_cmd_pos(input int aw, input int bw);
        return aw + bw;
    endfunction

    function automatic int cw_amode_lsb(input int aw, input int bw);
        return aw + bw + 1;
    endfunction

    // write-data word {last, byten, wdata}
    function automatic int dw_ben_lsb(input int dw);
        return dw;
    endfunction

    function automatic int dw_last_pos(input int dw);
        return dw + dw / 8;
    endfunction

    // read-data word {err, last, rdata}
    function automatic int rd_last_pos(input int dw);
        return dw;
    endfunction

    function automatic int rd_err_pos(input int dw);
        return dw + 1;
    endfunction

endpackage

// File: rtl/cbus_beat_calc.sv
// Beat count of a burst: ceil((bytecnt + address offset) / bytes-per-beat).
// Purely combinational; shared with the AXI-side engine.
module cbus_beat_calc
    import cbus2axi_pkg::*;
#(
    parameter int DW    = 32,
    parameter int BCW   = 10,
    parameter int OFFW  = offw(DW),
    parameter int BEATW = BCW - OFFW + 1
) (
    input  logic [BCW-1:0]   bytecnt,
    input  logic [OFFW-1:0]  addr_off,
    output logic [BEATW-1:0] beats
);

    logic [BCW:0] adj;

    assign adj = {1'b0, bytecnt}
               + {{(BCW + 1 - OFFW){1'b0}}, addr_off};

    // whole beats plus one for any partial tail
    assign beats = adj[BCW:OFFW]
                 + {{(BEATW - 1){1'b0}}, |adj[OFFW-1:0]};

endmodule

// File: rtl/cbus_mstr_if_wide.sv
// CBUS master front-end: turns CBUS bursts into command/write-data FIFO
// pushes, checks write burst length and returns read data with error.
module cbus_mstr_if_wide
    import cbus2axi_pkg::*;
#(
    parameter int DW    = 32,
    parameter int AW    = 32,
    parameter int BCW   = 10,
    parameter int BEATW = BCW - $clog2(DW / 8) + 1
) (
    input  logic                  aclk,
    input  logic                  areset_n,
    input  logic                  cbus_m_req,
    input  logic                  cbus_m_cmd,
    input  logic [AW-1:0]         cbus_m_address,
    input  logic [BCW-1:0]        cbus_m_bytecnt,
    input  logic [1:0]            cbus_m_amode,
    input  logic                  cbus_m_first,
    input  logic                  cbus_m_last,
    input  logic [DW/8-1:0]       cbus_m_byten,
    input  logic [DW-1:0]         cbus_m_wdata,
    output logic                  cbus_m_waccept,
    output logic                  cbus_m_rresp,
    output logic [DW-1:0]         cbus_m_rdatap,
    output logic                  cbus_m_rerr,
    output logic [AW+BEATW+2:0]   cwfifo_datain,
    output logic                  cwfifo_wr_op,
    input  logic                  cwfifo_afull,
    output logic [DW+DW/8:0]      dwfifo_datain,
    output logic                  dwfifo_wr_op,
    input  logic                  dwfifo_afull,
    input  logic [DW+1:0]         rdfifo_dataout,
    input  logic                  rdfifo_empty,
    output logic                  rdfifo_rd_op,
    output logic                  wr_len_err
);

    localparam int OFFW     = offw(DW);
    localparam int CW_BEATS = cw_beats_lsb(AW);
    localparam int CW_CMD   = cw_cmd_pos(AW, BEATW);
    localparam int CW_AMODE = cw_amode_lsb(AW, BEATW);
    localparam int DW_BEN   = dw_ben_lsb(DW);
    localparam int DW_LAST  = dw_last_pos(DW);
    localparam int RD_LAST  = rd_last_pos(DW);
    localparam int RD_ERR   = rd_err_pos(DW);

    mstr_st_e state_q, state_d;

    logic [BEATW-1:0]    beats;
    logic [BEATW-1:0]    cnt_q, exp_q;
    logic [BEATW-1:0]    cnt_nxt, exp_nxt;
    logic [AW+BEATW+2:0] cmd_word;
    logic [DW+DW/8:0]    data_word;
    logic wr_acc, wr_first, rd_push, rd_pop;
    logic cmd_push, len_bad;

    cbus_beat_calc #(
        .DW    (DW),
        .BCW   (BCW),
        .OFFW  (OFFW),
        .BEATW (BEATW)
    ) u_beat_calc (
        .bytecnt  (cbus_m_bytecnt),
        .addr_off (cbus_m_address[OFFW-1:0]),
        .beats    (beats)
    );

    // held off during reset so nothing is accepted mid-reset
    assign wr_acc = areset_n & cbus_m_req & ~cbus_m_cmd
                  & ~dwfifo_afull & (state_q != ST_RWAIT)
                  & (~cbus_m_first | ~cwfifo_afull);

    assign wr_first = wr_acc & cbus_m_first;
    assign rd_push  = (state_q == ST_IDLE) & cbus_m_req
                    & cbus_m_cmd & cbus_m_first & ~cwfifo_afull;
    assign rd_pop   = cbus_m_req & cbus_m_cmd
                    & (state_q == ST_RWAIT) & ~rdfifo_empty;
    assign cmd_push = wr_first | rd_push;

    assign cbus_m_waccept = wr_acc;
    assign cbus_m_rresp   = rd_pop;
    assign rdfifo_rd_op   = rd_pop;

    assign cnt_nxt = cbus_m_first ? {{(BEATW - 1){1'b0}}, 1'b1}
                                  : cnt_q + 1'b1;
    assign exp_nxt = cbus_m_first ? beats : exp_q;

    assign len_bad = wr_acc
                   & ((cbus_m_first & (state_q == ST_WBURST))
                   |  (cbus_m_last  & (cnt_nxt != exp_nxt)));

    always_comb begin
        cmd_word = '0;
        cmd_word[AW-1:0] = cbus_m_address;
        cmd_word[CW_BEATS +: BEATW] = beats;
        cmd_word[CW_CMD] = cbus_m_cmd;
        cmd_word[CW_AMODE +: 2] = cbus_m_amode;
    end

    always_comb begin
        data_word = '0;
        data_word[DW-1:0] = cbus_m_wdata;
        data_word[DW_BEN +: DW/8] = cbus_m_byten;
        data_word[DW_LAST] = cbus_m_last;
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_IDLE: begin
                if (rd_push)
                    state_d = ST_RWAIT;
                else if (wr_first & ~cbus_m_last)
                    state_d = ST_WBURST;
            end
            ST_WBURST: begin
                if (wr_acc & cbus_m_last)
                    state_d = ST_IDLE;
            end
            ST_RWAIT: begin
                if (rd_pop & rdfifo_dataout[RD_LAST])
                    state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge aclk or negedge areset_n) begin
        if (!areset_n) begin
            state_q       <= ST_IDLE;
            cnt_q         <= '0;
            exp_q         <= '0;
            cwfifo_wr_op  <= 1'b0;
            cwfifo_datain <= '0;
            dwfifo_wr_op  <= 1'b0;
            dwfifo_datain <= '0;
            cbus_m_rdatap <= '0;
            cbus_m_rerr   <= 1'b0;
            wr_len_err    <= 1'b0;
        end else begin
            state_q      <= state_d;
            cwfifo_wr_op <= cmd_push;
            dwfifo_wr_op <= wr_acc;
            wr_len_err   <= len_bad;
            if (cmd_push)
                cwfifo_datain <= cmd_word;
            if (wr_acc) begin
                dwfifo_datain <= data_word;
                cnt_q         <= cnt_nxt;
                exp_q         <= exp_nxt;
            end
            if (rd_pop) begin
                cbus_m_rdatap <= rdfifo_dataout[DW-1:0];
                cbus_m_rerr   <= rdfifo_dataout[RD_ERR];
            end
        end
    end

endmodule
